time_field_counter: RTL and testbench
=====================================

# time_field_counter

Parametrised time-field counter for one stopwatch or watch digit pair (hundredths, seconds, minutes, hours). Next generation of the per-field tick counter. It counts up or down on an incoming tick and chains carry or borrow to the next field. In set mode it edits the field with edge-detected inc/dec and hold-to-auto-repeat, and it supports parallel load. Instances are cascaded o_tick→i_tick inside the watch/timer datapath, with set-mode field select driven by the top-level control FSM.

## Interface
- MODULUS, 60: field counts 0..MODULUS-1; must be ≥2.
- WIDTH, 7: o_time/load_val width; must be ≥ $clog2(MODULUS).
- INIT_VALUE, 0: value after reset and after clear (e.g. 12 for hours); must be < MODULUS.
- WRAP_DOWN, 1: 1 = down count wraps 0→MODULUS-1 with borrow; 0 = down count saturates at 0.
- REPEAT_DLY, 50_000_000: cycles inc/dec must be held after the first step before auto-repeat starts.
- REPEAT_RATE, 10_000_000: cycles between auto-repeat steps.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- i_tick  in  1  single-cycle count pulse from the previous field or the tick generator.
- run  in  1  1 = i_tick counts; 0 = i_tick ignored.
- up_dn  in  1  1 = count up, 0 = count down (timer mode).
- set_en  in  1  this field is selected for editing.
- clear  in  1  return to INIT_VALUE; honoured only while set_en=1.
- inc  in  1  level from the debounced up button.
- dec  in  1  level from the debounced down button.
- load  in  1  single-cycle parallel load strobe.
- load_val  in  WIDTH  value to load.
- o_time  out  WIDTH  current field value, registered.
- o_tick  out  1  registered carry (up) or borrow (down) pulse to the next field.
- o_zero  out  1  registered, o_time==0.

## Operation
- Next-value priority, highest first: rst=0 → clear (set_en=1) → load → set-mode step → i_tick count. Only the highest active source takes effect in a cycle.
- Count: applies when i_tick=1, run=1 and set_en=0. Counting is frozen while the field is being edited.
  - Up: MODULUS-1→0 with o_tick=1; otherwise +1.
  - Down, value 0: if WRAP_DOWN=1 → MODULUS-1 with o_tick=1; if WRAP_DOWN=0 → stays 0 with o_tick=0.
  - Down, otherwise: -1.
- Load: o_time←load_val, clamped to MODULUS-1 when load_val≥MODULUS; no o_tick.
- Set-mode steps always wrap both directions (inc at MODULUS-1→0, dec at 0→MODULUS-1) and never assert o_tick.
- Auto-repeat FSM, one instance shared by inc and dec, with a cycle counter of width $clog2(max(REPEAT_DLY,REPEAT_RATE)+1):
  - IDLE: a rising edge of exactly one of inc/dec (previous-cycle registered copy low) with set_en=1 → one step, go to DELAY, counter=0.
  - DELAY: the same button held → counter++. At REPEAT_DLY-1 → one step, go to REPEAT, counter=0.
  - REPEAT: the same button held → counter++. At REPEAT_RATE-1 → one step, counter=0.
  - From any state → IDLE when the held button is released, the other button is also pressed, or set_en falls.
- inc and dec both high: no step; FSM goes to IDLE. A new step requires a fresh rising edge.
- o_zero is updated together with o_time.

## Timing
- Reset (rst=0 on a clk edge): o_time=INIT_VALUE, o_tick=0, o_zero=(INIT_VALUE==0), FSM=IDLE, repeat counter=0, button edge registers=0. Reset takes effect regardless of any other input.
- All outputs are registered; every event at edge N is visible after edge N+1.
- o_tick is exactly one cycle wide and aligned with the cycle in which o_time shows the wrapped value. The ripple through a cascade therefore costs one cycle per field.
- First set step: 1 cycle after the rising edge. Second step: REPEAT_DLY cycles after the first. Subsequent steps: every REPEAT_RATE cycles.
- An i_tick that coincides with clear, load or a step is dropped, not deferred.
- Reset asserted mid-repeat aborts immediately. After release, a button held through reset needs a new rising edge to step.

## Test plan
- MODULUS=60, up, run=1: load 58, two i_tick pulses → o_time 59, then 0 with o_tick=1 for one cycle, o_zero=1.
- MODULUS=60, down, WRAP_DOWN=1, value 0, i_tick → 59, o_tick=1. Repeat with WRAP_DOWN=0 → stays 0, o_tick=0, o_zero=1.
- MODULUS=24, INIT_VALUE=12: reset → 12. With set_en=1, dec pulse → 11. clear → 12. clear with set_en=0 → no change.
- REPEAT_DLY=4, REPEAT_RATE=2, set_en=1, value 0, hold inc 10 cycles → steps at cycles 1, 5, 7, 9 → o_time 4; release → no further steps.
- set_en=1 with i_tick pulses and run=1 → o_time unchanged. inc and dec raised together → no change. load_val=75 with MODULUS=60 → o_time=59.
- Mid-repeat (value 7), drive rst=0 for one cycle while inc stays high → o_time=INIT_VALUE; no step until inc drops and rises again.

Source files
------------

// File: rtl/time_field_counter_if.sv
// Control/data bundle for one time field: tick/edit/load inputs and value/carry outputs.
// Latency: none (wiring only); outputs are registered inside the counter.
// Backpressure: none; every strobe is a single-cycle pulse, dropped if it loses priority.
// Ports: i_tick, run, up_dn, set_en, clear, inc, dec, load, load_val -> counter;
//        o_time, o_tick, o_zero <- counter.
interface time_field_counter_if #(
  parameter int WIDTH = 7
);
  logic             i_tick;
  logic             run;
  logic             up_dn;
  logic             set_en;
  logic             clear;
  logic             inc;
  logic             dec;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] o_time;
  logic             o_tick;
  logic             o_zero;

  modport master (
    output i_tick, run, up_dn, set_en, clear, inc, dec, load, load_val,
    input  o_time, o_tick, o_zero
  );

  modport slave (
    input  i_tick, run, up_dn, set_en, clear, inc, dec, load, load_val,
    output o_time, o_tick, o_zero
  );
endinterface

// File: rtl/time_field_counter.sv
// Modulo-N time field: tick count up/down with carry/borrow, set-mode edit with auto-repeat, load.
// Latency: 1 cycle from any input event to o_time/o_tick/o_zero.
// Backpressure: none; a lower-priority event in the same cycle is dropped, never deferred.
// Ports: clk, rst (sync active-low), bus (slave modport of time_field_counter_if).
module time_field_counter #(
  parameter int MODULUS     = 60,
  parameter int WIDTH       = 7,
  parameter int INIT_VALUE  = 0,
  parameter int WRAP_DOWN   = 1,
  parameter int REPEAT_DLY  = 50_000_000,
  parameter int REPEAT_RATE = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  time_field_counter_if.slave   bus
);

  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CW   = $clog2(RMAX + 1);

  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INITV    = WIDTH'(INIT_VALUE);
  localparam logic [CW-1:0]    DLY_END  = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0]    RATE_END = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    rcnt, rcnt_nxt;
  logic             dir_up, dir_up_nxt;
  logic             inc_q, dec_q;
  logic             inc_arm, dec_arm;
  logic             inc_rise, dec_rise, both, start, held_ok;
  logic             step, step_up;
  logic [WIDTH-1:0] value, value_nxt;
  logic             carry, carry_nxt;
  logic             zero;

  // A button held through reset must be seen low once before its edge counts,
  // otherwise the cleared edge register would fake a rising edge on release.
  assign inc_rise = bus.inc & ~inc_q & inc_arm;
  assign dec_rise = bus.dec & ~dec_q & dec_arm;
  assign both     = bus.inc & bus.dec;
  assign start    = bus.set_en & ~both & (inc_rise ^ dec_rise);
  assign held_ok  = bus.set_en & ~both & (dir_up ? bus.inc : bus.dec);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rcnt    <= '0;
      dir_up  <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      inc_arm <= 1'b0;
      dec_arm <= 1'b0;
    end else begin
      state   <= state_nxt;
      rcnt    <= rcnt_nxt;
      dir_up  <= dir_up_nxt;
      inc_q   <= bus.inc;
      dec_q   <= bus.dec;
      inc_arm <= inc_arm | ~bus.inc;
      dec_arm <= dec_arm | ~bus.dec;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    rcnt_nxt   = rcnt;
    dir_up_nxt = dir_up;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = DELAY;
          rcnt_nxt   = '0;
          dir_up_nxt = inc_rise;
        end
      end
      DELAY: begin
        if (!held_ok) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == DLY_END) begin
          state_nxt = REPEAT;
          rcnt_nxt  = '0;
        end else begin
          rcnt_nxt = rcnt + CW'(1);
        end
      end
      REPEAT: begin
        if (!held_ok) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else if (rcnt == RATE_END) begin
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end
    endcase
  end

  // Output logic: edit step request and its direction
  always_comb begin
    step    = 1'b0;
    step_up = dir_up;
    case (state)
      IDLE: begin
        step    = start;
        step_up = inc_rise;
      end
      DELAY:   step = held_ok & (rcnt == DLY_END);
      REPEAT:  step = held_ok & (rcnt == RATE_END);
      default: step = 1'b0;
    endcase
  end

  // Field value: clear > load > edit step > tick count
  always_comb begin
    value_nxt = value;
    carry_nxt = 1'b0;
    if (bus.clear && bus.set_en) begin
      value_nxt = INITV;
    end else if (bus.load) begin
      value_nxt = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    end else if (step) begin
      // Edits always wrap and never ripple into the next field.
      if (step_up) value_nxt = (value == MAXV) ? '0 : value + WIDTH'(1);
      else         value_nxt = (value == '0) ? MAXV : value - WIDTH'(1);
    end else if (bus.i_tick && bus.run && !bus.set_en) begin
      if (bus.up_dn) begin
        if (value == MAXV) begin
          value_nxt = '0;
          carry_nxt = 1'b1;
        end else begin
          value_nxt = value + WIDTH'(1);
        end
      end else if (value == '0) begin
        if (WRAP_DOWN != 0) begin
          value_nxt = MAXV;
          carry_nxt = 1'b1;
        end
      end else begin
        value_nxt = value - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= INITV;
      carry <= 1'b0;
      zero  <= (INITV == '0);
    end else begin
      value <= value_nxt;
      carry <= carry_nxt;
      zero  <= (value_nxt == '0);
    end
  end

  assign bus.o_time = value;
  assign bus.o_tick = carry;
  assign bus.o_zero = zero;

endmodule

// File: tb/tb_time_field_counter.sv
// Directed bench for time_field_counter across three parameter sets sharing clk/rst.
// Latency: results are checked 1 ns after the edge that should produce them.
// Backpressure: none; expectations are queued with stimulus and drained after each edge.
module tb_time_field_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  time_field_counter_if #(.WIDTH(7)) a ();
  time_field_counter_if #(.WIDTH(7)) b ();
  time_field_counter_if #(.WIDTH(7)) c ();

  // a: minutes-style field with wrapping borrow and a short repeat timing
  time_field_counter #(
    .MODULUS(60), .WIDTH(7), .INIT_VALUE(0), .WRAP_DOWN(1),
    .REPEAT_DLY(4), .REPEAT_RATE(2)
  ) u_a (.clk(clk), .rst(rst), .bus(a.slave));

  // b: saturating down count
  time_field_counter #(
    .MODULUS(60), .WIDTH(7), .INIT_VALUE(0), .WRAP_DOWN(0),
    .REPEAT_DLY(4), .REPEAT_RATE(2)
  ) u_b (.clk(clk), .rst(rst), .bus(b.slave));

  // c: hours-style field starting at 12
  time_field_counter #(
    .MODULUS(24), .WIDTH(7), .INIT_VALUE(12), .WRAP_DOWN(1),
    .REPEAT_DLY(4), .REPEAT_RATE(2)
  ) u_c (.clk(clk), .rst(rst), .bus(c.slave));

  typedef struct packed {
    logic [1:0] sel;
    logic [6:0] t;
    logic       tk;
    logic       z;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [8:0] observe(input logic [1:0] sel);
    case (sel)
      2'd0:    return {a.o_time, a.o_tick, a.o_zero};
      2'd1:    return {b.o_time, b.o_tick, b.o_zero};
      default: return {c.o_time, c.o_tick, c.o_zero};
    endcase
  endfunction

  task automatic expect_out(input string tag, input logic [1:0] sel,
                            input int t, input logic tk, input logic z);
    exp_t e;
    e.sel = sel;
    e.t   = 7'(t);
    e.tk  = tk;
    e.z   = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cycle();
    exp_t       e;
    string      tg;
    logic [8:0] obs;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tg  = tag_q.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === {e.t, e.tk, e.z}) else begin
        errors++;
        $error("FAIL %s: observed time=%0d tick=%0b zero=%0b, expected time=%0d tick=%0b zero=%0b",
               tg, obs[8:2], obs[1], obs[0], e.t, e.tk, e.z);
      end
    end
  endtask

  int hold_exp[10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

  initial begin
    a.i_tick = 0; a.run = 0; a.up_dn = 1; a.set_en = 0; a.clear = 0;
    a.inc = 0; a.dec = 0; a.load = 0; a.load_val = '0;
    b.i_tick = 0; b.run = 0; b.up_dn = 1; b.set_en = 0; b.clear = 0;
    b.inc = 0; b.dec = 0; b.load = 0; b.load_val = '0;
    c.i_tick = 0; c.run = 0; c.up_dn = 1; c.set_en = 0; c.clear = 0;
    c.inc = 0; c.dec = 0; c.load = 0; c.load_val = '0;

    // Reset state
    rst = 0;
    expect_out("reset_a", 0, 0, 0, 1);
    expect_out("reset_b", 1, 0, 0, 1);
    expect_out("reset_c", 2, 12, 0, 0);
    cycle();
    rst = 1;

    // Up count through the wrap
    a.run = 1; a.up_dn = 1; a.load = 1; a.load_val = 7'd58;
    expect_out("load58", 0, 58, 0, 0);
    cycle();
    a.load = 0; a.i_tick = 1;
    expect_out("up59", 0, 59, 0, 0);
    cycle();
    expect_out("up_wrap", 0, 0, 1, 1);
    cycle();
    a.i_tick = 0;
    expect_out("tick_one_cycle", 0, 0, 0, 1);
    cycle();

    // Down count from zero: wrapping and saturating variants
    a.up_dn = 0; a.i_tick = 1;
    b.run = 1; b.up_dn = 0; b.i_tick = 1;
    expect_out("down_wrap", 0, 59, 1, 0);
    expect_out("down_sat", 1, 0, 0, 1);
    cycle();
    a.i_tick = 0; b.i_tick = 0;
    expect_out("borrow_one_cycle", 0, 59, 0, 0);
    cycle();

    // Hours field: single dec edit, clear, clear ignored outside set mode
    c.set_en = 1; c.dec = 1;
    expect_out("dec_step", 2, 11, 0, 0);
    cycle();
    c.dec = 0;
    expect_out("dec_single", 2, 11, 0, 0);
    cycle();
    c.clear = 1;
    expect_out("clear", 2, 12, 0, 0);
    cycle();
    c.clear = 0; c.set_en = 0; c.load = 1; c.load_val = 7'd5;
    expect_out("load5", 2, 5, 0, 0);
    cycle();
    c.load = 0; c.clear = 1;
    expect_out("clear_no_set", 2, 5, 0, 0);
    cycle();
    c.clear = 0;

    // Auto-repeat: hold inc for 10 cycles from 0
    a.load = 1; a.load_val = 7'd0;
    expect_out("load0", 0, 0, 0, 1);
    cycle();
    a.load = 0; a.set_en = 1; a.inc = 1;
    for (int k = 0; k < 10; k++) begin
      expect_out($sformatf("hold%0d", k), 0, hold_exp[k], 0, 0);
      cycle();
    end
    a.inc = 0;
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("released%0d", k), 0, 4, 0, 0);
      cycle();
    end

    // Counting frozen during edit; both buttons; clamped load
    a.up_dn = 1; a.run = 1; a.i_tick = 1;
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("frozen%0d", k), 0, 4, 0, 0);
      cycle();
    end
    a.i_tick = 0; a.inc = 1; a.dec = 1;
    for (int k = 0; k < 2; k++) begin
      expect_out($sformatf("both%0d", k), 0, 4, 0, 0);
      cycle();
    end
    a.inc = 0; a.dec = 0;
    expect_out("both_release", 0, 4, 0, 0);
    cycle();
    a.set_en = 0; a.load = 1; a.load_val = 7'd75;
    expect_out("load_clamp", 0, 59, 0, 0);
    cycle();
    a.load = 0;

    // Reset in the middle of a repeat on the hours field
    c.set_en = 1; c.inc = 1;
    expect_out("rep_first", 2, 6, 0, 0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("rep_delay%0d", k), 2, 6, 0, 0);
      cycle();
    end
    expect_out("rep_second", 2, 7, 0, 0);
    cycle();
    rst = 0;
    expect_out("mid_reset_c", 2, 12, 0, 0);
    expect_out("mid_reset_a", 0, 0, 0, 1);
    cycle();
    rst = 1;
    for (int k = 0; k < 6; k++) begin
      expect_out($sformatf("held_after_reset%0d", k), 2, 12, 0, 0);
      cycle();
    end
    c.inc = 0;
    expect_out("inc_low", 2, 12, 0, 0);
    cycle();
    c.inc = 1;
    expect_out("fresh_edge", 2, 13, 0, 0);
    cycle();
    c.inc = 0; c.set_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
